cmp4_frame_tracker: RTL and testbench
=====================================

Name: cmp4_frame_tracker

Overview:
Downstream consumer of the 4-bit magnitude comparator. It accepts a stream of 4-bit samples over a valid/ready handshake and groups them into frames of FRAME_LEN samples. For each frame it tracks the running max and min, and counts rises, falls and repeats relative to the previous sample. All three relations come from comparator flags (A_Greater/Equal/B_Greater). One summary per frame is presented on a valid/ready output port.

Parameters:
FRAME_LEN, 16, samples per frame; legal range 2..255.
CNT_W, $clog2(FRAME_LEN), width of the event counters; holds FRAME_LEN-1.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
clear  in  1  synchronous frame abort, active high.
in_valid  in  1  sample present.
in_ready  out  1  block can accept a sample.
in_data  in  4  sample value, unsigned.
out_valid  out  1  frame summary available.
out_ready  in  1  consumer takes the summary.
out_max  out  4  largest sample in frame.
out_min  out  4  smallest sample in frame.
out_rise  out  CNT_W  count of samples greater than their predecessor.
out_fall  out  CNT_W  count of samples less than their predecessor.
out_eq  out  CNT_W  count of samples equal to their predecessor.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0, all registers and outputs are 0, state is FIRST, and no sample is accepted.
- Accept: a sample is taken when in_valid && in_ready on a rising clk edge.
- FSM states:
  - FIRST: in_ready=1. On accept, load max=min=prev=in_data, clear rise/fall/eq, set idx=1. Go to ACCUM.
  - ACCUM: in_ready=1. On accept, use comparator flags:
    - in_data vs max: if A_Greater, max<=in_data.
    - in_data vs min: if B_Greater, min<=in_data.
    - in_data vs prev: A_Greater increments rise, B_Greater increments fall, Equal increments eq.
    - Then prev<=in_data and idx<=idx+1.
    - On the accept where idx==FRAME_LEN-1, latch final values, including the update from this sample, into the out_* registers and go to DONE.
  - DONE: in_ready=0 and out_valid=1. The out_* values stay stable until out_valid && out_ready, then go to FIRST. No combinational path from out_ready to in_ready; the next frame's first sample can be accepted the cycle after the handshake.
- Latency: out_valid rises on the clk edge after the FRAME_LEN-th accepted sample.
- Invariant: out_rise + out_fall + out_eq == FRAME_LEN-1.
- Counters never wrap: the maximum count is FRAME_LEN-1, which fits CNT_W.
- out_* registers keep the last summary after the handshake; they are valid only while out_valid=1.
- clear has priority over accept and handshake in every state. It goes to FIRST, discards the partial frame, drops out_valid, and ignores any sample offered in the same cycle.
- rst_n asserted mid-frame or in DONE forces the reset values immediately, without waiting for clk. The pending summary is lost.
- in_valid gaps (bubbles) are allowed at any point; state is held.

Decomposition:
- Shared package cmp4_pkg holds:
  - enum tracker_state_t {FIRST, ACCUM, DONE};
  - typedef logic [3:0] nibble_t;
  - DEFAULT_FRAME_LEN = 16.
- Sub-module: three instances of the existing Four_Bit_Comparator_verilog, for sample-vs-max, sample-vs-min and sample-vs-prev. No other sub-modules; FSM and counters are inline.

Test Plan:
1. Ascending 0..15, FRAME_LEN=16, out_ready=1 -> one out_valid pulse; max=F, min=0, rise=15, fall=0, eq=0.
2. Sixteen samples of 7 -> max=7, min=7, rise=0, fall=0, eq=15.
3. Alternating 3,9,3,9,... (16 samples) -> max=9, min=3, rise=8, fall=7, eq=0. Also descending F..0 -> fall=15.
4. Backpressure: out_ready low for 5 cycles after out_valid -> in_ready=0, out_* stable throughout. Raise out_ready -> out_valid drops the next cycle, and a sample offered that cycle is accepted as FIRST.
5. clear after 6 accepted samples, with in_valid=1 on the same cycle -> no out_valid, that sample not counted. The next 16 samples (pattern 1) give max=F, min=0, rise=15.
6. rst_n pulsed low between clk edges mid-frame and in DONE -> all outputs 0 immediately. The first frame after release is summarised correctly, with random in_valid bubbles inserted.

Source files
------------

// File: rtl/cmp4_pkg.sv
// Shared types for the 4-bit comparator frame tracker.
package cmp4_pkg;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } tracker_state_t;

    typedef logic [3:0] nibble_t;

    // Packed comparator result, ordered {A_Greater, Equal, B_Greater}
    typedef struct packed {
        logic a_gt;
        logic eq;
        logic b_gt;
    } cmp_flags_t;

    localparam int DEFAULT_FRAME_LEN = 16;

endpackage

// File: rtl/Four_Bit_Comparator_verilog.sv
// Unsigned 4-bit magnitude comparator; exactly one flag is high for any A/B pair.
module Four_Bit_Comparator_verilog (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       A_Greater,
    output logic       Equal,
    output logic       B_Greater
);

    assign A_Greater = (A > B);
    assign Equal     = (A == B);
    assign B_Greater = (A < B);

endmodule

// File: rtl/cmp4_frame_tracker.sv
// Groups a 4-bit sample stream into frames and reports per-frame max/min and
// rise/fall/repeat counts, all derived from comparator flags.
//
// state | meaning
// FIRST | waiting for the first sample of a frame; loads max/min/prev
// ACCUM | folding samples 2..FRAME_LEN into the running statistics
// DONE  | summary presented on out_*; input stalled until consumer takes it
module cmp4_frame_tracker
    import cmp4_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_max,
    output logic [3:0]       out_min,
    output logic [CNT_W-1:0] out_rise,
    output logic [CNT_W-1:0] out_fall,
    output logic [CNT_W-1:0] out_eq
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    tracker_state_t state_q, state_nxt;

    logic             ready_q;
    nibble_t          max_q, min_q, prev_q;
    nibble_t          max_nxt, min_nxt;
    logic [CNT_W-1:0] rise_q, fall_q, eq_q, idx_q;
    logic [CNT_W-1:0] rise_nxt, fall_nxt, eq_nxt;
    cmp_flags_t       max_flags, min_flags, prev_flags;

    logic accept;
    logic load_first;
    logic accum;
    logic last;

    Four_Bit_Comparator_verilog u_cmp_max (
        .A         (in_data),
        .B         (max_q),
        .A_Greater (max_flags.a_gt),
        .Equal     (max_flags.eq),
        .B_Greater (max_flags.b_gt)
    );

    Four_Bit_Comparator_verilog u_cmp_min (
        .A         (in_data),
        .B         (min_q),
        .A_Greater (min_flags.a_gt),
        .Equal     (min_flags.eq),
        .B_Greater (min_flags.b_gt)
    );

    Four_Bit_Comparator_verilog u_cmp_prev (
        .A         (in_data),
        .B         (prev_q),
        .A_Greater (prev_flags.a_gt),
        .Equal     (prev_flags.eq),
        .B_Greater (prev_flags.b_gt)
    );

    // in_ready is a flop so out_ready never reaches it combinationally
    assign in_ready  = ready_q;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && ready_q && !clear;

    always_comb begin
        state_nxt  = state_q;
        load_first = 1'b0;
        accum      = 1'b0;
        last       = 1'b0;
        if (clear) begin
            state_nxt = FIRST;
        end else begin
            case (state_q)
                FIRST: begin
                    if (accept) begin
                        load_first = 1'b1;
                        state_nxt  = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        accum = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            last      = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt = FIRST;
                    end
                end
                default: state_nxt = FIRST;
            endcase
        end
    end

    always_comb begin
        max_nxt  = max_q;
        min_nxt  = min_q;
        rise_nxt = rise_q;
        fall_nxt = fall_q;
        eq_nxt   = eq_q;
        unique case (max_flags)
            3'b100:  max_nxt = in_data;
            default: max_nxt = max_q;
        endcase
        unique case (min_flags)
            3'b001:  min_nxt = in_data;
            default: min_nxt = min_q;
        endcase
        unique case (prev_flags)
            3'b100:  rise_nxt = rise_q + ONE;
            3'b001:  fall_nxt = fall_q + ONE;
            3'b010:  eq_nxt   = eq_q + ONE;
            default: eq_nxt   = eq_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIRST;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt != DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q    <= '0;
            min_q    <= '0;
            prev_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            eq_q     <= '0;
            idx_q    <= '0;
            out_max  <= '0;
            out_min  <= '0;
            out_rise <= '0;
            out_fall <= '0;
            out_eq   <= '0;
        end else if (load_first) begin
            max_q  <= in_data;
            min_q  <= in_data;
            prev_q <= in_data;
            rise_q <= '0;
            fall_q <= '0;
            eq_q   <= '0;
            idx_q  <= ONE;
        end else if (accum) begin
            max_q  <= max_nxt;
            min_q  <= min_nxt;
            prev_q <= in_data;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
            eq_q   <= eq_nxt;
            if (last) begin
                out_max  <= max_nxt;
                out_min  <= min_nxt;
                out_rise <= rise_nxt;
                out_fall <= fall_nxt;
                out_eq   <= eq_nxt;
            end else begin
                idx_q <= idx_q + ONE;
            end
        end
    end

endmodule

// File: tb/tb_cmp4_frame_tracker.sv
// Directed bench for cmp4_frame_tracker with FRAME_LEN=16.
module tb_cmp4_frame_tracker;

    localparam int FL = 16;
    localparam int CW = $clog2(FL);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_data = 4'h0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_max, out_min;
    logic [CW-1:0] out_rise, out_fall, out_eq;

    int n_cmp  = 0;
    int n_fail = 0;

    cmp4_frame_tracker #(.FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_rise  (out_rise),
        .out_fall  (out_fall),
        .out_eq    (out_eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] pat;    // sample i in bits [4i+3:4i]
        logic [3:0]  e_max;
        logic [3:0]  e_min;
        int          e_rise;
        int          e_fall;
        int          e_eq;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives samples first..first+n-1 of pat, one accept per call iteration
    task automatic send_samples(input logic [63:0] pat, input int first, input int n,
                                input bit bubbles, input string tag);
        int budget;
        for (int i = first; i < first + n; i++) begin
            if (bubbles) begin
                for (int b = 0; b < 3 && $urandom_range(0, 2) == 0; b++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            budget = 40;
            while (!in_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (!in_ready) begin
                check({tag, "_ready_timeout"}, 0, 1);
                return;
            end
            in_valid = 1'b1;
            in_data  = pat[4*i +: 4];
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_summary(input vec_t v);
        check({v.name, "_valid"},    int'(out_valid), 1);
        check({v.name, "_in_ready"}, int'(in_ready),  0);
        check({v.name, "_max"},      int'(out_max),   int'(v.e_max));
        check({v.name, "_min"},      int'(out_min),   int'(v.e_min));
        check({v.name, "_rise"},     int'(out_rise),  v.e_rise);
        check({v.name, "_fall"},     int'(out_fall),  v.e_fall);
        check({v.name, "_eq"},       int'(out_eq),    v.e_eq);
    endtask

    task automatic run_frame(input vec_t v, input bit bubbles);
        send_samples(v.pat, 0, FL - 1, bubbles, v.name);
        check({v.name, "_early_valid"}, int'(out_valid), 0);
        send_samples(v.pat, FL - 1, 1, bubbles, v.name);
        check_summary(v);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_in_ready"},  int'(in_ready),  0);
        check({tag, "_out_max"},   int'(out_max),   0);
        check({tag, "_out_min"},   int'(out_min),   0);
        check({tag, "_out_cnts"},  int'(out_rise) + int'(out_fall) + int'(out_eq), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stable_ok;
        vecs[0] = '{"ascend",  64'hFEDCBA9876543210, 4'hF, 4'h0, 15, 0, 0};
        vecs[1] = '{"const7",  64'h7777777777777777, 4'h7, 4'h7, 0, 0, 15};
        vecs[2] = '{"alt39",   64'h9393939393939393, 4'h9, 4'h3, 8, 7, 0};
        vecs[3] = '{"descend", 64'h0123456789ABCDEF, 4'hF, 4'h0, 0, 15, 0};
        vecs[4] = '{"mixed",   64'h6FF0443CCC188255, 4'hF, 4'h0, 4, 5, 6};
        vecs[5] = '{"inner",   64'h92A864577399BA68, 4'hB, 4'h2, 7, 6, 2};

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven frames with the consumer always ready
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            run_frame(vecs[k], 1'b0);
            @(negedge clk);
            check({vecs[k].name, "_ack_drop"}, int'(out_valid), 0);
        end

        // Backpressure: summary held for 5 cycles, then released
        out_ready = 1'b0;
        run_frame(vecs[4], 1'b0);
        stable_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 4'h3;
            @(negedge clk);
            if (!out_valid || in_ready || out_max != 4'hF || out_min != 4'h0 ||
                out_rise != 4 || out_fall != 5 || out_eq != 6)
                stable_ok = 1'b0;
        end
        check("bp_stable", int'(stable_ok), 1);
        out_ready = 1'b1;
        in_data   = vecs[5].pat[3:0];
        @(negedge clk);
        check("bp_valid_drop", int'(out_valid), 0);
        check("bp_ready_back", int'(in_ready),  1);
        run_frame(vecs[5], 1'b0);
        @(negedge clk);

        // Clear after 6 samples, with a sample offered alongside
        send_samples(64'h0000_0000_0022_2222, 0, 6, 1'b0, "clr_pre");
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h5;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_no_valid", int'(out_valid), 0);
        check("clr_ready",    int'(in_ready),  1);
        run_frame(vecs[0], 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-frame
        send_samples(vecs[2].pat, 0, 5, 1'b0, "rst_mid_pre");
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_mid");
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset while holding a summary in DONE
        out_ready = 1'b0;
        run_frame(vecs[5], 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_done");
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // First frame after reset, with random input bubbles
        out_ready = 1'b1;
        run_frame(vecs[4], 1'b1);
        @(negedge clk);
        check("post_rst_ack_drop", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
